// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch, decode, execute, memory and
// write-back over one shared datapath, and halts on illegal encodings or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       br_taken_i,
  output logic       imem_valid_o,
  input  logic       imem_ready_i,
  output logic       dmem_valid_o,
  output logic       dmem_we_o,
  input  logic       dmem_ready_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic [2:0] imm_sel_o,
  output logic [1:0] alu_mode_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  // FETCH read instr | DECODE classify | EXEC alu/branch | MEM data access | WB writeback | HALT stop
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_R = 4'd0, C_IALU = 4'd1, C_LUI = 4'd2, C_AUIPC = 4'd3, C_LOAD = 4'd4,
    C_STORE = 4'd5, C_BRANCH = 4'd6, C_JAL = 4'd7, C_JALR = 4'd8
  } class_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  class_e     class_q, class_d, dec_class;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d, fault_q, fault_d;
  logic       dec_illegal, dec_sys;

  always_comb begin
    dec_class   = C_R;
    dec_illegal = 1'b0;
    dec_sys     = 1'b0;
    case (opcode_i)
      7'h33: begin
        dec_class = C_R;
        if (funct7_i == 7'h20) dec_illegal = !(funct3_i == 3'd0 || funct3_i == 3'd5);
        else                   dec_illegal = (funct7_i != 7'h00);
      end
      7'h13: dec_class = C_IALU;
      7'h03: begin
        dec_class   = C_LOAD;
        dec_illegal = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
      end
      7'h23: begin
        dec_class   = C_STORE;
        dec_illegal = (funct3_i > 3'd2);
      end
      7'h63: begin
        dec_class   = C_BRANCH;
        dec_illegal = (funct3_i == 3'd2) || (funct3_i == 3'd3);
      end
      7'h37: dec_class = C_LUI;
      7'h17: dec_class = C_AUIPC;
      7'h6F: dec_class = C_JAL;
      7'h67: begin
        dec_class   = C_JALR;
        dec_illegal = (funct3_i != 3'd0);
      end
      7'h73: begin
        dec_illegal = (funct3_i != 3'd0);
        dec_sys     = (funct3_i == 3'd0);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready_i) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (dec_sys) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            wait_d  = 8'd0;
          end
          C_BRANCH, C_JAL, C_JALR: begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready_i) begin
          if (class_q == C_STORE) begin
            state_d = S_FETCH;
            wait_d  = 8'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      class_q   <= C_R;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    imem_valid_o = 1'b0;
    dmem_valid_o = 1'b0;
    dmem_we_o    = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_o     = 2'd0;
    rf_we_o      = 1'b0;
    wb_sel_o     = 2'd0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 1'b0;
    imm_sel_o    = 3'd0;
    alu_mode_o   = 2'd0;
    retire_o     = 1'b0;
    // ALU controls are held through MEM and WB so the address/result stays stable
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (class_q)
        C_R:      alu_mode_o = 2'd1;
        C_IALU:   begin alu_src_b_o = 1'b1; alu_mode_o = 2'd1; end
        C_LUI:    begin imm_sel_o = 3'd3; alu_mode_o = 2'd3; end
        C_AUIPC:  begin alu_src_a_o = 1'b1; alu_src_b_o = 1'b1; imm_sel_o = 3'd3; end
        C_LOAD:   alu_src_b_o = 1'b1;
        C_STORE:  begin alu_src_b_o = 1'b1; imm_sel_o = 3'd1; end
        C_BRANCH: begin imm_sel_o = 3'd2; alu_mode_o = 2'd2; end
        C_JAL:    imm_sel_o = 3'd4;
        default:  imm_sel_o = 3'd0;
      endcase
    end
    case (state_q)
      S_FETCH: begin
        imem_valid_o = 1'b1;
        ir_we_o      = imem_ready_i;
      end
      S_DECODE: retire_o = dec_sys;
      S_EXEC: begin
        case (class_q)
          C_BRANCH: begin
            pc_we_o  = 1'b1;
            pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
            retire_o = 1'b1;
          end
          C_JAL, C_JALR: begin
            rf_we_o  = 1'b1;
            wb_sel_o = 2'd2;
            pc_we_o  = 1'b1;
            pc_sel_o = (class_q == C_JAL) ? 2'd1 : 2'd2;
            retire_o = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_valid_o = 1'b1;
        dmem_we_o    = (class_q == C_STORE);
        if (dmem_ready_i && class_q == C_STORE) begin
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
        end
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (class_q == C_LOAD) ? 2'd1 : 2'd0;
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
      end
      default: ;
    endcase
    if (rst_i) begin
      imem_valid_o = 1'b0;
      dmem_valid_o = 1'b0;
      dmem_we_o    = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      rf_we_o      = 1'b0;
      retire_o     = 1'b0;
    end
  end

  assign illegal_o = illegal_q;
  assign fault_o   = fault_q;
  assign state_o   = state_q;

endmodule
